// File: rtl/ram_arb_pkg.sv
// Shared constants and FSM encoding for the RAM port arbiter.
package ram_arb_pkg;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned AW_DEF   = 4;
  localparam int unsigned DW_DEF   = 4;
  localparam int unsigned LOCK_MAX = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first active request after last_winner, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last_winner,
  output logic [NREQ-1:0] winner,
  output logic            any
);

  logic          found;
  logic [LW-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    any    = |req;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = LW'((32'(last_winner) + k) % NREQ);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one synchronous-read memory port among NREQ requesters.
// Define RAM_ARB_LOCK_EN to add the lock port and capped burst re-grants.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned DW   = DW_DEF
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
`ifdef RAM_ARB_LOCK_EN
  input  logic [NREQ-1:0]   lock,
`endif
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [DW-1:0]     rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata
);

  localparam int unsigned LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            state_q, state_d;
  logic [LW-1:0]     last_q, last_d;
  logic [NREQ-1:0]   gnt_q, gnt_d, rvalid_q, rvalid_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_d;

  logic [NREQ-1:0]   pick_winner, grant_vec;
  logic              pick_any, grant_any, relock;
  logic [LW-1:0]     win_idx;
  logic              sel_we;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_wdata;

  rr_pick #(.NREQ(NREQ), .LW(LW)) u_pick (
    .req         (req),
    .last_winner (last_q),
    .winner      (pick_winner),
    .any         (pick_any)
  );

`ifdef RAM_ARB_LOCK_EN
  localparam int unsigned CW = $clog2(LOCK_MAX);
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          after_gnt_q;

  // Re-grant only in the IDLE cycle right after a grant, until LOCK_MAX consecutive grants.
  assign relock = after_gnt_q && req[last_q] && lock[last_q] &&
                  (lock_cnt_q < CW'(LOCK_MAX - 1));

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (state_q == IDLE && grant_any) lock_cnt_d = relock ? lock_cnt_q + CW'(1) : '0;
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      lock_cnt_q  <= '0;
      after_gnt_q <= 1'b0;
    end else begin
      lock_cnt_q  <= lock_cnt_d;
      after_gnt_q <= (state_q == GRANT);
    end
  end
`else
  assign relock = 1'b0;
`endif

  assign grant_vec = relock ? (NREQ'(1) << last_q) : pick_winner;
  assign grant_any = relock | pick_any;

  always_comb begin
    win_idx   = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant_vec[i]) begin
        win_idx   = LW'(i);
        sel_we    = we[i];
        sel_addr  = addr[i*AW +: AW];
        sel_wdata = wdata[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any) state_d = GRANT;
      GRANT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d       = '0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    last_d      = last_q;
    rvalid_d    = (mem_en_q && !mem_we_q) ? gnt_q : '0;
    if (state_q == IDLE && grant_any) begin
      gnt_d       = grant_vec;
      mem_en_d    = 1'b1;
      mem_we_d    = sel_we;
      mem_addr_d  = sel_addr;
      mem_wdata_d = sel_wdata;
      last_d      = win_idx;
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      gnt_q       <= '0;
      rvalid_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      last_q      <= LW'(NREQ - 1);
    end else begin
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      last_q      <= last_d;
    end
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  // Memory read data arrives one cycle after the command; pass it through while valid.
  assign rdata     = (|rvalid_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a synchronous-read memory model.
module tb_ram_port_arbiter;

  logic        clk1 = 1'b0;
  logic        rst;
  logic [3:0]  req, we, lock;
  logic [15:0] addr, wdata;
  logic [3:0]  gnt, rvalid, rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_addr, mem_wdata;
  logic [3:0]  mem_rdata = 4'h0;
  logic [3:0]  mem [16];

  int total = 0;
  int bad   = 0;

  always #5 clk1 = ~clk1;

  ram_port_arbiter dut (
    .clk1      (clk1),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
`ifdef RAM_ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always @(posedge clk1) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'h0;
    rst = 1'b1; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    rst = 1'b0;

    // write by requester 0
    req = 4'b0001; we = 4'b0001; addr[0 +: 4] = 4'd6; wdata[0 +: 4] = 4'hA;
    tick();
    chk("wr0_gnt", 32'(gnt), 32'h1);
    chk("wr0_mem_en", 32'(mem_en), 32'h1);
    chk("wr0_mem_we", 32'(mem_we), 32'h1);
    chk("wr0_mem_addr", 32'(mem_addr), 32'h6);
    chk("wr0_mem_wdata", 32'(mem_wdata), 32'hA);
    req = '0;
    tick();
    chk("wr0_idle_gnt", 32'(gnt), 32'h0);
    chk("wr0_no_rvalid", 32'(rvalid), 32'h0);

    // read by requester 2
    req = 4'b0100; we = 4'b0000; addr[8 +: 4] = 4'd6;
    tick();
    chk("rd2_gnt", 32'(gnt), 32'h4);
    chk("rd2_mem_we", 32'(mem_we), 32'h0);
    chk("rd2_mem_addr", 32'(mem_addr), 32'h6);
    req = '0;
    tick();
    chk("rd2_rvalid", 32'(rvalid), 32'h4);
    chk("rd2_rdata", 32'(rdata), 32'hA);
    chk("rd2_gnt_off", 32'(gnt), 32'h0);
    tick();
    chk("rd2_rvalid_off", 32'(rvalid), 32'h0);

    // write by 3, read back by 1
    req = 4'b1000; we = 4'b1000; addr[12 +: 4] = 4'd9; wdata[12 +: 4] = 4'h5;
    tick();
    chk("wr3_gnt", 32'(gnt), 32'h8);
    chk("wr3_mem_addr", 32'(mem_addr), 32'h9);
    chk("wr3_mem_wdata", 32'(mem_wdata), 32'h5);
    req = '0;
    tick();
    req = 4'b0010; we = 4'b0000; addr[4 +: 4] = 4'd9;
    tick();
    chk("rd1_gnt", 32'(gnt), 32'h2);
    req = '0;
    tick();
    chk("rd1_rvalid", 32'(rvalid), 32'h2);
    chk("rd1_rdata", 32'(rdata), 32'h5);

    // all requesting: strict rotation with an idle cycle between grants
    do_reset();
    req = 4'b1111; we = 4'b0000; addr = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rot%0d_gnt", k), 32'(gnt), 32'(4'b0001 << (k % 4)));
      tick();
      chk($sformatf("rot%0d_idle", k), 32'(gnt), 32'h0);
      chk($sformatf("rot%0d_rvalid", k), 32'(rvalid), 32'(4'b0001 << (k % 4)));
    end

    // reset during a read grant aborts it
    req = 4'b0110;
    tick();
    chk("abort_gnt_pre", 32'(gnt), 32'h2);
    rst = 1'b1;
    #1;
    chk("abort_gnt_async", 32'(gnt), 32'h0);
    chk("abort_mem_en_async", 32'(mem_en), 32'h0);
    chk("abort_rvalid_async", 32'(rvalid), 32'h0);
    tick();
    rst = 1'b0;
    req = 4'b1010;
    chk("abort_rvalid_rel", 32'(rvalid), 32'h0);
    tick();
    chk("abort_lowest_gnt", 32'(gnt), 32'h2);
    chk("abort_rvalid_gnt", 32'(rvalid), 32'h0);
    req = '0;
    tick();
    chk("abort_new_rvalid", 32'(rvalid), 32'h2);

    // requester 3 withdraws before being granted
    req = 4'b1001;
    #3;
    req = 4'b0001;
    tick();
    chk("drop_gnt", 32'(gnt), 32'h1);
    req = '0;
    tick();
    chk("drop_idle1", 32'(gnt), 32'h0);
    tick();
    chk("drop_idle2", 32'(gnt), 32'h0);

`ifdef RAM_ARB_LOCK_EN
    // lock held by requester 1: four consecutive grants, then requester 0
    do_reset();
    lock = 4'b0010; req = 4'b0011; we = 4'b0000;
    begin
      logic [3:0] exp_seq [6];
      exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0010;
      exp_seq[3] = 4'b0010; exp_seq[4] = 4'b0010; exp_seq[5] = 4'b0001;
      for (int k = 0; k < 6; k++) begin
        tick();
        chk($sformatf("lock%0d_gnt", k), 32'(gnt), 32'(exp_seq[k]));
        tick();
        chk($sformatf("lock%0d_idle", k), 32'(gnt), 32'h0);
      end
    end
    req = '0; lock = '0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one memory port.
REQ-002 Parameter AW, default 4: memory address width.
REQ-003 Parameter DW, default 4: memory data width.
REQ-004 clk1  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req  in  NREQ  per-requester access request; held until matching gnt bit seen.
REQ-007 we  in  NREQ  per-requester write (1) / read (0) select, valid with req.
REQ-008 addr  in  NREQ*AW  packed addresses, requester i at bits [i*AW +: AW].
REQ-009 wdata  in  NREQ*DW  packed write data, requester i at bits [i*DW +: DW].
REQ-010 lock  in  NREQ  burst-lock hint; present only with RAM_ARB_LOCK_EN.
REQ-011 gnt  out  NREQ  one-hot grant, registered.
REQ-012 rvalid  out  NREQ  one-hot read-data-valid.
REQ-013 rdata  out  DW  read data, meaningful only while any rvalid bit is high.
REQ-014 mem_en, mem_we  out  1 each  memory port enable / write enable.
REQ-015 mem_addr  out  AW; mem_wdata  out  DW; mem_rdata  in  DW: synchronous-read memory port, one-cycle read latency.

Function
REQ-016 FSM states: IDLE, GRANT.
REQ-017 IDLE: any req bit high at the edge -> GRANT; winner chosen by round-robin; else stay IDLE.
REQ-018 GRANT lasts exactly one cycle, then IDLE; req is ignored while in GRANT.
REQ-019 In GRANT: gnt[winner]=1, mem_en=1, mem_we=we[winner], mem_addr/mem_wdata = winner's captured addr/wdata; all other gnt bits 0.
REQ-020 Request sampled at edge N -> gnt and memory command in cycle N+1 -> for reads, rvalid[winner]=1 and rdata=mem_rdata in cycle N+2.
REQ-021 A write grant produces no rvalid.
REQ-022 Round-robin: search starts at last_winner+1 modulo NREQ and wraps; last_winner updates on every grant.
REQ-023 At most one gnt bit and at most one rvalid bit are high in any cycle; maximum throughput is one access per two cycles.
REQ-024 A requester dropping req before grant is legal; that request is lost with no gnt.
REQ-025 All requests simultaneous: grants issue in strict rotation, each requester at most once per NREQ grants.

Reset
REQ-026 rst asserted: state=IDLE; gnt, rvalid, mem_en, mem_we = 0; mem_addr, mem_wdata, rdata = 0; last_winner=NREQ-1; all asynchronous.
REQ-027 Reset during GRANT or with a read in flight aborts the access: no rvalid is produced after reset release.
REQ-028 The first arbitration after reset grants the lowest-index active requester.

Configuration
REQ-029 Macro RAM_ARB_LOCK_EN compiles in the lock port and a consecutive-grant counter (reset 0).
REQ-030 With RAM_ARB_LOCK_EN: if lock[winner] and req[winner] are high in the IDLE cycle after a grant, the same requester is re-granted without advancing last_winner.
REQ-031 With RAM_ARB_LOCK_EN: lock-held re-grants are capped at 4 consecutive grants; the next arbitration then follows round-robin, and the counter clears.
REQ-032 Without RAM_ARB_LOCK_EN: lock port absent; pure round-robin.

Structure
REQ-033 Shared package ram_arb_pkg holds the FSM state encoding, the default AW/DW/NREQ constants and LOCK_MAX=4.
REQ-034 Sub-module rr_pick: combinational round-robin picker with inputs req and last_winner, outputs one-hot winner and any.

Verification
REQ-035 Reset, then req=4'b0001, we=1, addr0=6, wdata0=4'hA -> gnt=4'b0001 one cycle later; mem_we=1, mem_addr=6, mem_wdata=4'hA.
REQ-036 Read by requester 2 at addr 6 after the write -> gnt[2], then next cycle rvalid=4'b0100 with rdata=4'hA.
REQ-037 req=4'b1111 held continuously -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-038 rst pulsed during GRANT of a read -> gnt=0 immediately; no rvalid after release; next grant goes to the lowest active index.
REQ-039 RAM_ARB_LOCK_EN, lock[1]=1, req=4'b0011 held -> requester 1 granted 4 consecutive times, then requester 0.
REQ-040 Requester 3 drops req before grant while req[0] stays high -> only gnt[0] ever asserts.
